// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, data width.
package lsu_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } lsu_state_t;

    function automatic logic is_sub_word(input logic [1:0] sz);
        return (sz == SZ_B) || (sz == SZ_H);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Datapath-side request/response bundle of the load/store unit.
interface lsu_if;
    import lsu_pkg::*;

    logic              req;
    logic              store;
    logic [1:0]        size;
    logic              uns;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              ready;
    logic              done;
    logic [WORD_W-1:0] rdata;
    logic              err;

    modport master (
        output req, store, size, uns, addr, wdata,
        input  ready, done, rdata, err
    );

    modport slave (
        input  req, store, size, uns, addr, wdata,
        output ready, done, rdata, err
    );

endinterface

// File: rtl/lsu_lane.sv
// Byte/halfword lane logic: extract-and-extend for loads, lane merge for sub-word stores.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        ofs,
    input  logic              uns,
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] ext,
    output logic [WORD_W-1:0] merged
);

    logic [WORD_W-1:0] sh_b;
    logic [WORD_W-1:0] sh_h;

    always_comb begin
        sh_b   = word >> {ofs, 3'b000};
        sh_h   = word >> {ofs[1], 4'b0000};
        ext    = word;
        merged = wdata;
        case (size)
            SZ_B: begin
                ext    = {{24{~uns & sh_b[7]}}, sh_b[7:0]};
                merged = word;
                merged[{ofs, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                ext    = {{16{~uns & sh_h[15]}}, sh_h[15:0]};
                merged = word;
                merged[{ofs[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                ext    = word;
                merged = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for the word-addressed data memory (RMW for sub-word stores).
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    lsu_if.slave              bus,
    output logic [WORD_W-1:0] mem_a,
    output logic [WORD_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [WORD_W-1:0] mem_rd
);

    lsu_state_t        state, state_n;
    logic              r_store;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] wbuf;
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] lane_word;
    logic [WORD_W-1:0] lane_ext;
    logic [WORD_W-1:0] lane_merged;
    logic              misalign;

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;

    always_comb begin
        misalign = ((bus.size == SZ_H) && bus.addr[0]) ||
                   ((bus.size == SZ_W) && (bus.addr[1:0] != 2'b00)) ||
                   (bus.size == 2'b11);
    end
`else
    always_comb begin
        misalign = 1'b0;
    end
`endif

    // Loads extract straight from the memory during READ so rdata is valid on entry to DONE.
    always_comb begin
        lane_word = (state == READ) ? mem_rd : wbuf;
    end

    lsu_lane u_lane (
        .size   (r_size),
        .ofs    (r_addr[1:0]),
        .uns    (r_uns),
        .word   (lane_word),
        .wdata  (r_wdata),
        .ext    (lane_ext),
        .merged (lane_merged)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (misalign)
                        state_n = DONE;
                    else if (bus.store && !is_sub_word(bus.size))
                        state_n = WRITE;
                    else
                        state_n = READ;
                end
            end
            READ:    state_n = r_store ? WRITE : DONE;
            WRITE:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Memory-side outputs are state-decoded and forced to 0 while rst is high.
    always_comb begin
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        if (!rst) begin
            case (state)
                READ: mem_a = {r_addr[WORD_W-1:2], 2'b00};
                WRITE: begin
                    mem_a  = {r_addr[WORD_W-1:2], 2'b00};
                    mem_we = 1'b1;
                    mem_wd = is_sub_word(r_size) ? lane_merged : r_wdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ready = (state == IDLE);
        bus.done  = (state == DONE) && !rst;
        bus.rdata = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        bus.err   = (state == DONE) && !rst && err_q;
`else
        bus.err   = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            r_store <= 1'b0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            wbuf    <= '0;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (state == IDLE && bus.req) begin
                r_store <= bus.store;
                r_size  <= bus.size;
                r_uns   <= bus.uns;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                err_q   <= misalign;
`endif
            end
            if (state == READ) begin
                wbuf <= mem_rd;
                if (!r_store)
                    rdata_q <= lane_ext;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a 64-word behavioural data memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    lsu_if bus ();

    load_store_unit dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_we (mem_we),
        .mem_rd (mem_rd)
    );

    logic [31:0] mem [0:63];
    logic        poke_en;
    logic [5:0]  poke_idx;
    logic [31:0] poke_val;

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we)  mem[mem_a[7:2]] <= mem_wd;
        if (poke_en) mem[poke_idx]   <= poke_val;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          lat;
    int          we_cnt;
    int          done_cnt;
    logic [31:0] we_addr;
    logic [31:0] amax;
    logic        op_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = a[7:2];
        poke_val = v;
        @(negedge clk);
        poke_en  = 1'b0;
    endtask

    // Issue one request and follow it to done, recording latency and write activity.
    task automatic do_op(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.store = st;
        bus.size  = sz;
        bus.uns   = un;
        bus.addr  = a;
        bus.wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req   = 1'b0;
        bus.addr  = 32'hFFFF_FFFC;
        bus.wdata = 32'h0;
        bus.uns   = ~un;
        lat = 0; we_cnt = 0; we_addr = '0; amax = '0; op_err = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_a;
            end
            if (mem_a > amax) amax = mem_a;
            if (bus.done) begin
                lat    = c;
                op_err = bus.err;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 1'b0; bus.store = 1'b0; bus.size = SZ_W; bus.uns = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        poke_en = 1'b0; poke_idx = '0; poke_val = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, bus.ready}, 32'd1);
        check("rst_done",  {31'b0, bus.done},  32'd0);
        check("rst_err",   {31'b0, bus.err},   32'd0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_wd", mem_wd, 32'h0);
        rst = 1'b0;

        // Word store then word load
        do_op(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check("sw_lat", lat, 2);
        check("sw_we_cnt", we_cnt, 1);
        check("sw_we_addr", we_addr, 32'h10);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        @(negedge clk);
        check("sw_ready_after", {31'b0, bus.ready}, 32'd1);
        do_op(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        check("lw_lat", lat, 2);
        check("lw_rdata", bus.rdata, 32'hDEAD_BEEF);
        check("lw_err", {31'b0, op_err}, 32'd0);
        check("lw_we_cnt", we_cnt, 0);

        // Byte / half load extension
        poke(32'h20, 32'h80FF_7F01);
        do_op(1'b0, SZ_B, 1'b0, 32'h23, 32'h0);
        check("lb_23_s", bus.rdata, 32'hFFFF_FF80);
        do_op(1'b0, SZ_B, 1'b1, 32'h23, 32'h0);
        check("lb_23_u", bus.rdata, 32'h0000_0080);
        do_op(1'b0, SZ_B, 1'b0, 32'h21, 32'h0);
        check("lb_21_s", bus.rdata, 32'h0000_007F);
        do_op(1'b0, SZ_H, 1'b0, 32'h22, 32'h0);
        check("lh_22_s", bus.rdata, 32'hFFFF_80FF);
        do_op(1'b0, SZ_H, 1'b1, 32'h20, 32'h0);
        check("lh_20_u", bus.rdata, 32'h0000_7F01);

        // Sub-word read-modify-write stores
        poke(32'h30, 32'h1122_3344);
        do_op(1'b1, SZ_B, 1'b0, 32'h31, 32'h1234_56AA);
        check("sb_lat", lat, 3);
        check("sb_we_cnt", we_cnt, 1);
        check("sb_mem", mem[12], 32'h1122_AA44);
        do_op(1'b1, SZ_H, 1'b0, 32'h32, 32'h5555_BEEF);
        check("sh_lat", lat, 3);
        check("sh_mem", mem[12], 32'hBEEF_AA44);
        check("st_rdata_kept", bus.rdata, 32'h0000_7F01);

        // Reset during WRITE of a word store
        poke(32'h40, 32'h1111_2222);
        @(negedge clk);
        bus.req = 1'b1; bus.store = 1'b1; bus.size = SZ_W; bus.addr = 32'h40; bus.wdata = 32'h5;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        check("rw_we_pre", {31'b0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("rw_we_rst", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rw_ready", {31'b0, bus.ready}, 32'd1);
        check("rw_done",  {31'b0, bus.done},  32'd0);
        check("rw_err",   {31'b0, bus.err},   32'd0);
        check("rw_rdata", bus.rdata, 32'h0);
        check("rw_mem_a", mem_a, 32'h0);
        check("rw_mem_wd", mem_wd, 32'h0);
        check("rw_mem_we", {31'b0, mem_we}, 32'd0);
        check("rw_mem", mem[16], 32'h1111_2222);
        @(negedge clk);
        check("rw_done_late", {31'b0, bus.done}, 32'd0);

        // Misaligned word load from 0x42
        do_op(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        check("pre_mis_rdata", bus.rdata, 32'hDEAD_BEEF);
        do_op(1'b0, SZ_W, 1'b0, 32'h42, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_lat", lat, 1);
        check("mis_err", {31'b0, op_err}, 32'd1);
        check("mis_mem_a", amax, 32'h0);
        check("mis_rdata", bus.rdata, 32'hDEAD_BEEF);
`else
        check("mis_lat", lat, 2);
        check("mis_err", {31'b0, op_err}, 32'd0);
        check("mis_rdata", bus.rdata, 32'h1111_2222);
`endif

        // Request while busy is ignored
        @(negedge clk);
        bus.req = 1'b1; bus.store = 1'b0; bus.size = SZ_W; bus.uns = 1'b0; bus.addr = 32'h30;
        @(posedge clk);
        @(negedge clk);
        bus.store = 1'b1; bus.addr = 32'h30; bus.wdata = 32'h0;
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) bus.req = 1'b0;
            if (bus.done) done_cnt++;
        end
        check("busy_done_cnt", done_cnt, 1);
        check("busy_rdata", bus.rdata, 32'hBEEF_AA44);
        check("busy_mem", mem[12], 32'hBEEF_AA44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator for the word-addressed data memory `MemData`. It sits between the processor datapath and that memory. It turns byte, halfword and word load/store requests into whole-word accesses on the memory's `A`/`WD`/`WE`/`RD` interface. Sub-word stores use read-modify-write. Loads are extracted and sign- or zero-extended.

## Interface
Parameters:
- None. Data and address widths are fixed at 32 bits, and the memory is word-addressed by `A[31:2]`.

Ports:
- `clk` in 1: single clock; the memory writes on the same `posedge clk`.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: request strobe; accepted only when `ready`=1.
- `store` in 1: 1 = store, 0 = load.
- `size` in 2: access size; `SZ_B`=00, `SZ_H`=01, `SZ_W`=10; 11 is treated as word.
- `uns` in 1: load is zero-extended when 1, sign-extended when 0.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned (the byte is in [7:0], the half is in [15:0]).
- `ready` out 1: unit is idle and can accept a request.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: load result; valid while `done`=1 and held until the next load completes.
- `err` out 1: misaligned access (only with the macro); pulses together with `done`.
- `mem_a` out 32: drives memory `A`; bits [1:0] are always 0.
- `mem_wd` out 32: drives memory `WD`.
- `mem_we` out 1: drives memory `WE`.
- `mem_rd` in 32: from memory `RD`; combinational read of `mem_a`.

## Operation
FSM states: `IDLE`, `READ`, `WRITE`, `DONE`.

- `IDLE`:
  - `ready`=1.
  - On `req`, register `store`, `size`, `uns`, `addr`, `wdata`.
  - Next state is `READ` for a load or a sub-word store, and `WRITE` for a word store.
- `READ`:
  - `mem_a`={addr[31:2],2'b00}.
  - `mem_rd` is captured into the word buffer at the closing edge.
  - Next state is `WRITE` for a store and `DONE` for a load.
- `WRITE`:
  - `mem_we`=1.
  - `mem_wd` is either the merged word (sub-word store) or `wdata` (word store).
  - Next state is `DONE`.
- `DONE`:
  - `done`=1.
  - `rdata` is updated at entry, for loads only.
  - Next state is `IDLE`.

Load extraction:
- Byte: `buf >> (8*addr[1:0])`, bits [7:0].
- Half: `buf >> (16*addr[1])`, bits [15:0].
- The result is extended according to `uns`.

Store merge:
- The addressed byte or halfword lane of the word buffer is replaced by `wdata[7:0]` or `wdata[15:0]`.
- All other lanes keep their read value.

Rules:
- `req` outside `IDLE` is ignored and not queued.
- Inputs are sampled only in the acceptance cycle and may change afterwards.
- `mem_we` = (state==`WRITE`) && !`rst`. A reset asserted during `WRITE` suppresses the write.
- Reset at any point aborts the operation, with no `done` pulse. The next state is `IDLE`.
- Reset values:
  - state `IDLE`.
  - `ready`=1.
  - `done`=0, `err`=0.
  - `rdata`=0.
  - `mem_a`=0, `mem_wd`=0, `mem_we`=0.
  - word buffer 0.

## Timing
Request accepted at edge N:
- Load: `READ` in cycle N+1, `done` in N+2, `ready` again in N+3. Latency is 2 cycles.
- Word store: `WRITE` in N+1 (memory updated at the end of N+1), `done` in N+2.
- Sub-word store: `READ` in N+1, `WRITE` in N+2, `done` in N+3.
- Back-to-back issue: the earliest next acceptance is the cycle after `DONE`.
- Outputs `mem_a` and `mem_wd` are registered or state-decoded. They hold 0 in `IDLE`.

## Configuration
`LSU_MISALIGN_TRAP_EN`:
- Defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, goes directly `IDLE`→`DONE`.
  - `err`=1 with `done`; there is no memory access, and `rdata` is unchanged.
  - Size 11 also traps.
- Undefined:
  - `err` is tied to 0.
  - Misaligned addresses are truncated to alignment: half uses `addr[1]`, word ignores `addr[1:0]`.
  - Size 11 behaves as word.

## Structure
- Package `lsu_pkg`:
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`.
  - FSM state enum.
  - `WORD_W`=32.
- Sub-module `lsu_lane`: combinational byte/halfword extract-and-extend plus merge, selected by `size`, `addr[1:0]` and `uns`.
- The FSM and registers stay in `load_store_unit`.

## Test plan
- Word store then load:
  - Store 0xDEADBEEF at 0x10. `mem_we` is high for exactly one cycle, with `mem_a`=0x10.
  - Load word from 0x10. `done` 2 cycles after acceptance, `rdata`=0xDEADBEEF.
- Byte load extension:
  - Memory word at 0x20 = 0x80FF7F01.
  - Load byte from 0x23 signed → 0xFFFFFF80; unsigned → 0x00000080.
  - Load byte from 0x21 → 0x0000007F.
- Sub-word store read-modify-write:
  - Word 0x11223344 at 0x30.
  - Store byte 0xAA at 0x31 → memory 0x1122AA44.
  - Store half 0xBEEF at 0x32 → 0xBEEFAA44.
  - `done` at N+3 in each case.
- Reset during `WRITE`:
  - Assert `rst` in the `WRITE` cycle of a store of 0x5 to 0x40.
  - Required: memory unchanged, no `done`, `ready`=1 next cycle, all outputs at their reset values.
- Misaligned word load from 0x42:
  - With the macro: `done`=1 and `err`=1 one cycle after acceptance, `mem_a` stays 0.
  - Without the macro: the word at 0x40 is returned and `err`=0.
- Request while busy: a second `req` during `READ` is ignored, and exactly one `done` occurs.
